// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge-detection path.
// The window index order is shared with sobel_data_buffer.
package sobel_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned GRAD_W = 11;
  localparam int unsigned MAG_W  = 11;
  localparam int unsigned ABS_W  = 10;
  localparam int unsigned WIN_N  = 9;

  localparam logic [PIX_W-1:0] THRESHOLD_DEF = 8'd128;

  // Row-major 3x3 window: top-left .. bottom-right
  localparam int unsigned IDX_TL = 0;
  localparam int unsigned IDX_TC = 1;
  localparam int unsigned IDX_TR = 2;
  localparam int unsigned IDX_ML = 3;
  localparam int unsigned IDX_MC = 4;
  localparam int unsigned IDX_MR = 5;
  localparam int unsigned IDX_BL = 6;
  localparam int unsigned IDX_BC = 7;
  localparam int unsigned IDX_BR = 8;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef pix_t [WIN_N-1:0]         win_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [ABS_W-1:0]         gabs_t;

  // Gradients never reach -1024, so negation cannot overflow.
  function automatic gabs_t grad_abs(input grad_t g);
    grad_t n;
    n = g[GRAD_W-1] ? -g : g;
    return n[ABS_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_gradient_if.sv
// 3x3 window bundle with its valid qualifier, as produced by the line buffer.
interface sobel_gradient_if;

  sobel_pkg::win_t win;
  logic            done;

  modport master (output win, output done);
  modport slave  (input  win, input  done);

endinterface

// File: rtl/sobel_conv3x3.sv
// Combinational horizontal/vertical Sobel gradients from one 3x3 window.
module sobel_conv3x3
  import sobel_pkg::*;
(
  sobel_gradient_if.slave win_if,
  output grad_t           gx_o,
  output grad_t           gy_o
);

  function automatic grad_t ext(input pix_t p);
    return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction

  grad_t gx_pos, gx_neg, gy_pos, gy_neg;

  always_comb begin
    gx_pos = ext(win_if.win[IDX_TR]) + (ext(win_if.win[IDX_MR]) <<< 1) + ext(win_if.win[IDX_BR]);
    gx_neg = ext(win_if.win[IDX_TL]) + (ext(win_if.win[IDX_ML]) <<< 1) + ext(win_if.win[IDX_BL]);
    gy_pos = ext(win_if.win[IDX_BL]) + (ext(win_if.win[IDX_BC]) <<< 1) + ext(win_if.win[IDX_BR]);
    gy_neg = ext(win_if.win[IDX_TL]) + (ext(win_if.win[IDX_TC]) <<< 1) + ext(win_if.win[IDX_TR]);
  end

  assign gx_o = gx_pos - gx_neg;
  assign gy_o = gy_pos - gy_neg;

endmodule

// File: rtl/sobel_gradient.sv
// 3-stage Sobel magnitude pipeline with edge flag and per-frame edge-pixel counter.
module sobel_gradient
  import sobel_pkg::*;
#(
  parameter logic [PIX_W-1:0] THRESHOLD = THRESHOLD_DEF,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       d0_i,
  input  logic [7:0]       d1_i,
  input  logic [7:0]       d2_i,
  input  logic [7:0]       d3_i,
  input  logic [7:0]       d4_i,
  input  logic [7:0]       d5_i,
  input  logic [7:0]       d6_i,
  input  logic [7:0]       d7_i,
  input  logic [7:0]       d8_i,
  input  logic             done_i,
  output logic [7:0]       grayscale_o,
  output logic             edge_o,
  output logic             done_o,
  output logic [CNT_W-1:0] edge_cnt_o,
  output logic             frame_end_o
);

  sobel_gradient_if win_if ();

  assign win_if.win  = {d8_i, d7_i, d6_i, d5_i, d4_i, d3_i, d2_i, d1_i, d0_i};
  assign win_if.done = done_i;

  grad_t gx_c, gy_c;

  sobel_conv3x3 u_conv (
    .win_if (win_if.slave),
    .gx_o   (gx_c),
    .gy_o   (gy_c)
  );

  grad_t            gx_d, gx_q, gy_d, gy_q;
  logic             v1_d, v1_q;
  gabs_t            ax_d, ax_q, ay_d, ay_q;
  logic             v2_d, v2_q;
  logic [MAG_W-1:0] sum_c;
  logic [PIX_W-1:0] gray_d, gray_q;
  logic             edge_d, edge_q;
  logic             done_d, done_q;
  logic             prev_done_d, prev_done_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    gx_d = gx_c;
    gy_d = gy_c;
    v1_d = win_if.done;

    ax_d = grad_abs(gx_q);
    ay_d = grad_abs(gy_q);
    v2_d = v1_q;

    sum_c  = {1'b0, ax_q} + {1'b0, ay_q};
    gray_d = (sum_c > MAG_W'(255)) ? '1 : sum_c[PIX_W-1:0];
    edge_d = (gray_d >= THRESHOLD);
    done_d = v2_q;

    prev_done_d = done_q;
  end

  // Counter tracks the stage-3 outputs one cycle behind, so it has absorbed
  // the last pixel by the cycle done_o falls.
  always_comb begin
    cnt_d = cnt_q;
    if (done_q && !prev_done_q) begin
      cnt_d = CNT_W'(edge_q);
    end else if (done_q && edge_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gx_q        <= '0;
      gy_q        <= '0;
      v1_q        <= 1'b0;
      ax_q        <= '0;
      ay_q        <= '0;
      v2_q        <= 1'b0;
      gray_q      <= '0;
      edge_q      <= 1'b0;
      done_q      <= 1'b0;
      prev_done_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      v1_q        <= v1_d;
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      v2_q        <= v2_d;
      gray_q      <= gray_d;
      edge_q      <= edge_d;
      done_q      <= done_d;
      prev_done_q <= prev_done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign grayscale_o = gray_q;
  assign edge_o      = edge_q;
  assign done_o      = done_q;
  assign edge_cnt_o  = cnt_q;
  assign frame_end_o = prev_done_q & ~done_q;

endmodule

// File: tb/tb_sobel_gradient.sv
// Directed bench for sobel_gradient: vector table, frame bursts, mid-frame reset.
module tb_sobel_gradient;
  import sobel_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_gradient_if src_if ();

  logic [7:0]  gray, gray40, gray2;
  logic        edg, edg40, edg2;
  logic        done, done40, done2;
  logic [15:0] cnt, cnt40;
  logic [1:0]  cnt2;
  logic        fe, fe40, fe2;

  sobel_gradient dut (
    .clk(clk), .rst(rst),
    .d0_i(src_if.win[0]), .d1_i(src_if.win[1]), .d2_i(src_if.win[2]),
    .d3_i(src_if.win[3]), .d4_i(src_if.win[4]), .d5_i(src_if.win[5]),
    .d6_i(src_if.win[6]), .d7_i(src_if.win[7]), .d8_i(src_if.win[8]),
    .done_i(src_if.done), .grayscale_o(gray), .edge_o(edg), .done_o(done),
    .edge_cnt_o(cnt), .frame_end_o(fe)
  );

  sobel_gradient #(.THRESHOLD(8'd40)) dut40 (
    .clk(clk), .rst(rst),
    .d0_i(src_if.win[0]), .d1_i(src_if.win[1]), .d2_i(src_if.win[2]),
    .d3_i(src_if.win[3]), .d4_i(src_if.win[4]), .d5_i(src_if.win[5]),
    .d6_i(src_if.win[6]), .d7_i(src_if.win[7]), .d8_i(src_if.win[8]),
    .done_i(src_if.done), .grayscale_o(gray40), .edge_o(edg40), .done_o(done40),
    .edge_cnt_o(cnt40), .frame_end_o(fe40)
  );

  sobel_gradient #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .d0_i(src_if.win[0]), .d1_i(src_if.win[1]), .d2_i(src_if.win[2]),
    .d3_i(src_if.win[3]), .d4_i(src_if.win[4]), .d5_i(src_if.win[5]),
    .d6_i(src_if.win[6]), .d7_i(src_if.win[7]), .d8_i(src_if.win[8]),
    .done_i(src_if.done), .grayscale_o(gray2), .edge_o(edg2), .done_o(done2),
    .edge_cnt_o(cnt2), .frame_end_o(fe2)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic win_t mkw(input pix_t p0, input pix_t p1, input pix_t p2,
                               input pix_t p3, input pix_t p4, input pix_t p5,
                               input pix_t p6, input pix_t p7, input pix_t p8);
    win_t w;
    w[0] = p0; w[1] = p1; w[2] = p2;
    w[3] = p3; w[4] = p4; w[5] = p5;
    w[6] = p6; w[7] = p7; w[8] = p8;
    return w;
  endfunction

  typedef struct {
    win_t       win;
    logic [7:0] gray;
    logic       edg;
    logic       edg40;
  } vec_t;

  localparam int unsigned NV = 10;
  vec_t vec [NV];
  win_t w_uni, w_edge;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    w_uni  = mkw(50, 50, 50, 50, 50, 50, 50, 50, 50);
    w_edge = mkw(0, 255, 255, 0, 255, 255, 0, 255, 255);

    vec[0] = '{w_uni, 8'd0, 1'b0, 1'b0};
    vec[1] = '{mkw(0, 0, 10, 0, 0, 10, 0, 0, 10), 8'd40, 1'b0, 1'b1};
    vec[2] = '{mkw(0, 0, 9, 0, 0, 9, 0, 0, 9), 8'd36, 1'b0, 1'b0};
    vec[3] = '{w_edge, 8'd255, 1'b1, 1'b1};
    vec[4] = '{mkw(255, 255, 0, 255, 255, 0, 255, 255, 0), 8'd255, 1'b1, 1'b1};
    vec[5] = '{mkw(0, 0, 0, 0, 0, 0, 0, 0, 30), 8'd60, 1'b0, 1'b1};
    vec[6] = '{mkw(0, 0, 0, 0, 0, 0, 0, 0, 64), 8'd128, 1'b1, 1'b1};
    vec[7] = '{mkw(0, 0, 0, 0, 0, 0, 0, 0, 63), 8'd126, 1'b0, 1'b1};
    vec[8] = '{mkw(0, 64, 0, 0, 0, 0, 0, 0, 0), 8'd128, 1'b1, 1'b1};
    vec[9] = '{mkw(0, 0, 0, 0, 0, 0, 100, 100, 100), 8'd255, 1'b1, 1'b1};

    rst = 1'b0;
    src_if.win  = '0;
    src_if.done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gray", gray, 0);
    chk("rst_edge", edg, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_frame_end", fe, 0);
    chk("rst_cnt2", cnt2, 0);
    rst = 1'b1;

    // Isolated single-pixel frames: exact 3-cycle latency, then frame_end.
    for (int i = 0; i < NV; i++) begin
      src_if.win  = vec[i].win;
      src_if.done = 1'b1;
      @(negedge clk);
      src_if.done = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_done_early", i), done, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_gray", i), gray, vec[i].gray);
      chk($sformatf("v%0d_edge", i), edg, vec[i].edg);
      chk($sformatf("v%0d_gray40", i), gray40, vec[i].gray);
      chk($sformatf("v%0d_edge40", i), edg40, vec[i].edg40);
      chk($sformatf("v%0d_fe_early", i), fe, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_off", i), done, 0);
      chk($sformatf("v%0d_fe", i), fe, 1);
      chk($sformatf("v%0d_cnt", i), cnt, vec[i].edg);
      chk($sformatf("v%0d_cnt40", i), cnt40, vec[i].edg40);
    end
    @(negedge clk);

    // 36-window alternating frame, one idle cycle, then a 4-window all-edge frame.
    for (int c = 0; c < 50; c++) begin
      int  k;
      bit  ed, ep, ee;
      k  = c - 3;
      ed = (k >= 0 && k <= 35) || (k >= 37 && k <= 40);
      ep = (k - 1 >= 0 && k - 1 <= 35) || (k - 1 >= 37 && k - 1 <= 40);
      ee = (k >= 37) || (k % 2 == 1);
      chk($sformatf("burst_done_c%0d", c), done, ed);
      chk($sformatf("burst_fe_c%0d", c), fe, ep && !ed);
      if (ed) begin
        chk($sformatf("burst_gray_c%0d", c), gray, ee ? 255 : 0);
        chk($sformatf("burst_edge_c%0d", c), edg, ee);
      end
      if (c == 39) begin
        chk("frame1_cnt", cnt, 18);
        chk("frame1_cnt2_sat", cnt2, 3);
      end
      if (c == 40) chk("frame2_rise_cnt_hold", cnt, 18);
      if (c == 41) chk("frame2_restart_cnt", cnt, 1);
      if (c == 44) begin
        chk("frame2_cnt", cnt, 4);
        chk("frame2_cnt2_sat", cnt2, 3);
      end
      if (c == 48) chk("idle_cnt_hold", cnt, 4);

      if (c <= 35) begin
        src_if.win  = (c % 2 == 1) ? w_edge : w_uni;
        src_if.done = 1'b1;
      end else if (c >= 37 && c <= 40) begin
        src_if.win  = w_edge;
        src_if.done = 1'b1;
      end else begin
        src_if.done = 1'b0;
      end
      @(negedge clk);
    end

    // One-cycle reset mid-frame with windows still in flight.
    for (int j = 0; j < 6; j++) begin
      if (j == 5) begin
        chk("pre_rst_cnt", cnt, 2);
        chk("pre_rst_done", done, 1);
        rst = 1'b0;
      end
      src_if.win  = w_edge;
      src_if.done = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    src_if.done = 1'b0;
    chk("post_rst_gray", gray, 0);
    chk("post_rst_edge", edg, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_cnt", cnt, 0);
    chk("post_rst_fe", fe, 0);
    chk("post_rst_cnt2", cnt2, 0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk($sformatf("flushed_done_%0d", j), done, 0);
      chk($sformatf("flushed_cnt_%0d", j), cnt, 0);
      chk($sformatf("flushed_fe_%0d", j), fe, 0);
    end

    src_if.win  = w_edge;
    src_if.done = 1'b1;
    @(negedge clk);
    src_if.done = 1'b0;
    repeat (2) @(negedge clk);
    chk("after_rst_done", done, 1);
    @(negedge clk);
    chk("after_rst_fe", fe, 1);
    chk("after_rst_cnt", cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sobel_gradient.md
Name: sobel_gradient

Overview:
- Downstream neighbour of sobel_data_buffer. Consumes its 3x3 window (d0_i..d8_i) and its qualifier done_i.
- Computes the Sobel gradients Gx and Gy, then the L1 magnitude |Gx|+|Gy| saturated to 8 bits, plus an edge flag.
- 3-stage pipeline; the qualifier is delayed to match, so the output pairs directly with a writeback or display stage.
- Keeps a per-frame count of edge pixels for software or status readout.

Parameters:
- THRESHOLD, 8'd128, magnitude at or above which edge_o = 1.
- CNT_W, 16, width of the edge-pixel counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- d0_i..d8_i  in  8 each  unsigned window pixels. Row-major: d0 top-left, d4 centre, d8 bottom-right.
- done_i  in  1  window valid this cycle. A high run of done_i marks one frame.
- grayscale_o  out  8  saturated gradient magnitude.
- edge_o  out  1  grayscale_o >= THRESHOLD; qualified by done_o.
- done_o  out  1  done_i delayed 3 cycles.
- edge_cnt_o  out  CNT_W  count of edge pixels in the current or last frame.
- frame_end_o  out  1  one-cycle pulse on the falling edge of done_o; edge_cnt_o is final on that cycle.

Behaviour:
- Reset (rst == 0 at a clk edge) clears all pipeline registers and outputs to 0: grayscale_o, edge_o, done_o, edge_cnt_o, frame_end_o, and the internal previous-done flag.
- Reset mid-frame drops every in-flight result; no done_o appears for it.
- Stage 1, registered:
  - Gx = (d2 + 2*d5 + d8) - (d0 + 2*d3 + d6)
  - Gy = (d6 + 2*d7 + d8) - (d0 + 2*d1 + d2)
  - Both 11-bit signed, range -1020..+1020; no overflow is possible.
  - v1 <= done_i.
- Stage 2, registered: ax = |Gx|, ay = |Gy|, each 10-bit unsigned (max 1020); v2 <= v1.
- Stage 3, registered:
  - sum = ax + ay, 11-bit (max 2040).
  - grayscale_o = (sum > 255) ? 255 : sum[7:0].
  - edge_o = (saturated value >= THRESHOLD).
  - done_o <= v2.
- Latency is exactly 3 cycles, done_i to done_o. Throughput is 1 window per cycle with no stalls.
- Pipeline data registers update every cycle regardless of done. Outputs are don't-care while done_o = 0, but they must be deterministic.
- Edge counter (operates on stage-3 outputs):
  - Frame start = the cycle done_o rises (done_o = 1, previous done_o = 0). On that cycle edge_cnt_o loads edge_o ? 1 : 0, which clears the old count.
  - While done_o = 1 and not at frame start: increment when edge_o = 1.
  - Saturates at all-ones and does not wrap.
  - Holds its value while done_o = 0.
- frame_end_o = 1 for exactly one cycle when the previous done_o = 1 and the current done_o = 0.
- Back-to-back frames separated by a single low cycle: frame_end_o pulses, then the counter clears on the next rise.
- A single-cycle done_i produces a frame of 1 pixel: counter = 0 or 1, and frame_end_o pulses 1 cycle later.

Decomposition:
- Shared package sobel_pkg holds:
  - PIX_W = 8.
  - GRAD_W = 11 (signed gradient width).
  - MAG_W = 11.
  - Default THRESHOLD.
  - The window index ordering d0..d8, shared with sobel_data_buffer.
- One natural sub-module: sobel_conv3x3. Combinational Gx/Gy from the 9 pixels, instantiated before the stage-1 registers. It is reusable for other 3x3 kernels.
- Counter and pipeline registers stay in sobel_gradient.

Test Plan:
- Uniform window, all d = 50, done_i high 1 cycle → 3 cycles later: done_o = 1, grayscale_o = 0, edge_o = 0.
- d2 = d5 = d8 = 10, others 0 → Gx = 40, Gy = 0; grayscale_o = 40, edge_o = 0, exactly 3 cycles after input.
- d0 = d3 = d6 = 0, others 255 → Gx = 1020, Gy = 0; grayscale_o = 255 (saturated), edge_o = 1. Then mirror it (d2 = d5 = d8 = 0, others 255) → Gx = -1020, same output, which checks the abs path.
- 36-cycle done_i burst alternating the uniform and vertical-edge windows → done_o high exactly 36 cycles, delayed 3. frame_end_o pulses once after them, with edge_cnt_o = 18. A second 4-window all-edge burst after one idle cycle → count restarts and ends at 4.
- Assert rst = 0 for 1 cycle mid-burst, with 2 windows in flight → all outputs 0 the next cycle; the in-flight results never appear on done_o; edge_cnt_o = 0 until the next frame.
- THRESHOLD = 40 override with the d2/d5/d8 = 10 window → edge_o = 1 (boundary is inclusive). With d = 9 instead → grayscale_o = 36, edge_o = 0.
